// File: rtl/m_drop_controller.sv
`default_nettype none
// ============================================================================
//  Module   : m_drop_controller
//  Brief    : Connect-Four move sequencer. Takes one column request at a time,
//             rejects illegal or full columns, animates the falling piece row
//             by row and commits it. Owns the per-column piled counts, the
//             move counter and the player turn.
//  Revision : 1.0 - initial release
// ============================================================================
module m_drop_controller #(
    parameter int NUM_COLS   = 7,
    parameter int NUM_ROWS   = 6,
    parameter int FALL_TICKS = 1000000
) (
    input  wire logic                    i_clk,
    input  wire logic                    i_rst,
    input  wire logic                    i_new_game,
    input  wire logic                    i_req_valid,
    input  wire logic [2:0]              i_req_col,
    output logic                         o_req_ready,
    output logic                         o_reject,
    output logic                         o_anim_valid,
    output logic [2:0]                   o_anim_row,
    output logic [2:0]                   o_anim_col,
    output logic                         o_commit_valid,
    output logic [2:0]                   o_commit_row,
    output logic [2:0]                   o_commit_col,
    output logic                         o_commit_player,
    output logic                         o_turn,
    output logic [3*NUM_COLS-1:0]        o_piled_count_array,
    output logic [5:0]                   o_move_count,
    output logic                         o_board_full
);

    localparam int c_ROW_W  = 3;
    localparam int c_ARR_W  = c_ROW_W * NUM_COLS;
    localparam int c_TICK_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam logic [5:0]          c_MAX_MOVES = 6'(NUM_COLS * NUM_ROWS);
    localparam logic [2:0]          c_FULL_FIELD = 3'(NUM_ROWS);
    localparam logic [2:0]          c_TOP_ROW    = 3'(NUM_ROWS - 1);
    localparam logic [c_TICK_W-1:0] c_LAST_TICK  = c_TICK_W'(FALL_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FALL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic                  r_ready, w_ready_next;
    logic                  r_reject, w_reject_next;
    logic                  r_anim_valid, w_anim_valid_next;
    logic [2:0]            r_anim_row, w_anim_row_next;
    logic [2:0]            r_col, w_col_next;
    logic [2:0]            r_target, w_target_next;
    logic [c_TICK_W-1:0]   r_tick, w_tick_next;
    logic                  r_commit_valid, w_commit_valid_next;
    logic [2:0]            r_commit_row, w_commit_row_next;
    logic [2:0]            r_commit_col, w_commit_col_next;
    logic                  r_commit_player, w_commit_player_next;
    logic                  r_turn, w_turn_next;
    logic [c_ARR_W-1:0]    r_array, w_array_next;
    logic [5:0]            r_move_count, w_move_count_next;
    logic                  r_board_full, w_board_full_next;

    logic [2:0]            w_req_field;
    logic                  w_req_in_range;
    logic                  w_req_legal;
    logic [5:0]            w_count_inc;

    // Look up the piled count of the requested column; out-of-range columns never match.
    always_comb begin
        w_req_field    = 3'd0;
        w_req_in_range = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (i_req_col == 3'(c)) begin
                w_req_field    = r_array[c*c_ROW_W +: c_ROW_W];
                w_req_in_range = 1'b1;
            end
        end
        w_req_legal = w_req_in_range && (w_req_field != c_FULL_FIELD);
    end

    assign w_count_inc = r_move_count + 6'd1;

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        w_state_next         = r_state;
        w_ready_next         = r_ready;
        w_reject_next        = 1'b0;
        w_anim_valid_next    = r_anim_valid;
        w_anim_row_next      = r_anim_row;
        w_col_next           = r_col;
        w_target_next        = r_target;
        w_tick_next          = r_tick;
        w_commit_valid_next  = 1'b0;
        w_commit_row_next    = r_commit_row;
        w_commit_col_next    = r_commit_col;
        w_commit_player_next = r_commit_player;
        w_turn_next          = r_turn;
        w_array_next         = r_array;
        w_move_count_next    = r_move_count;
        w_board_full_next    = r_board_full;

        case (r_state)
            S_IDLE: begin
                w_ready_next = !r_board_full;
                if (i_req_valid && r_ready) begin
                    if (w_req_legal) begin
                        w_col_next        = i_req_col;
                        w_target_next     = w_req_field;
                        w_anim_row_next   = c_TOP_ROW;
                        w_tick_next       = '0;
                        w_anim_valid_next = 1'b1;
                        w_ready_next      = 1'b0;
                        w_state_next      = S_FALL;
                    end else begin
                        w_reject_next = 1'b1;
                    end
                end
            end

            S_FALL: begin
                w_ready_next = 1'b0;
                if (r_tick == c_LAST_TICK) begin
                    if (r_anim_row == r_target) begin
                        w_anim_valid_next    = 1'b0;
                        w_commit_valid_next  = 1'b1;
                        w_commit_row_next    = r_target;
                        w_commit_col_next    = r_col;
                        w_commit_player_next = r_turn;
                        w_state_next         = S_COMMIT;
                    end else begin
                        w_anim_row_next = r_anim_row - 3'd1;
                        w_tick_next     = '0;
                    end
                end else begin
                    w_tick_next = r_tick + c_TICK_W'(1);
                end
            end

            S_COMMIT: begin
                // Landing row equals the old field, so field+1 never exceeds NUM_ROWS.
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (r_col == 3'(c)) begin
                        w_array_next[c*c_ROW_W +: c_ROW_W] = r_array[c*c_ROW_W +: c_ROW_W] + 3'd1;
                    end
                end
                w_move_count_next = w_count_inc;
                w_turn_next       = !r_turn;
                w_board_full_next = r_board_full || (w_count_inc == c_MAX_MOVES);
                w_ready_next      = !w_board_full_next;
                w_state_next      = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset and new-game both clear everything, aborting any fall.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_new_game) begin
            r_state         <= S_IDLE;
            r_ready         <= 1'b0;
            r_reject        <= 1'b0;
            r_anim_valid    <= 1'b0;
            r_anim_row      <= 3'd0;
            r_col           <= 3'd0;
            r_target        <= 3'd0;
            r_tick          <= '0;
            r_commit_valid  <= 1'b0;
            r_commit_row    <= 3'd0;
            r_commit_col    <= 3'd0;
            r_commit_player <= 1'b0;
            r_turn          <= 1'b0;
            r_array         <= '0;
            r_move_count    <= 6'd0;
            r_board_full    <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_ready         <= w_ready_next;
            r_reject        <= w_reject_next;
            r_anim_valid    <= w_anim_valid_next;
            r_anim_row      <= w_anim_row_next;
            r_col           <= w_col_next;
            r_target        <= w_target_next;
            r_tick          <= w_tick_next;
            r_commit_valid  <= w_commit_valid_next;
            r_commit_row    <= w_commit_row_next;
            r_commit_col    <= w_commit_col_next;
            r_commit_player <= w_commit_player_next;
            r_turn          <= w_turn_next;
            r_array         <= w_array_next;
            r_move_count    <= w_move_count_next;
            r_board_full    <= w_board_full_next;
        end
    end

    assign o_req_ready         = r_ready;
    assign o_reject            = r_reject;
    assign o_anim_valid        = r_anim_valid;
    assign o_anim_row          = r_anim_row;
    assign o_anim_col          = r_col;
    assign o_commit_valid      = r_commit_valid;
    assign o_commit_row        = r_commit_row;
    assign o_commit_col        = r_commit_col;
    assign o_commit_player     = r_commit_player;
    assign o_turn              = r_turn;
    assign o_piled_count_array = r_array;
    assign o_move_count        = r_move_count;
    assign o_board_full        = r_board_full;

endmodule
`default_nettype wire
